tqvp_htfab_fb_sched: RTL
========================

TQVP_HTFAB_FB_SCHED -- requirements
Module: tqvp_htfab_fb_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port wr_valid  input  1  CPU row-write request.
REQ-005 SHALL have port wr_addr  input  4  target framebuffer row.
REQ-006 SHALL have port wr_data  input  32  row pixel word.
REQ-007 SHALL have port wr_ready  output  1  queue can accept; push occurs when wr_valid and wr_ready.
REQ-008 SHALL have port vblank  input  1  vertical-blank indication from VGA timing.
REQ-009 SHALL have port sync_mode  input  1  1 = commit only while vblank; 0 = commit any time.
REQ-010 SHALL have port fill_start  input  1  pulse starting hardware fill of all rows.
REQ-011 SHALL have port fill_pattern  input  32  word written to every row by fill.
REQ-012 SHALL have port fill_busy  output  1  fill engine active.
REQ-013 SHALL have port fb_we  output  1  framebuffer write strobe, one row per cycle.
REQ-014 SHALL have port fb_addr  output  4  framebuffer row address.
REQ-015 SHALL have port fb_data  output  32  framebuffer row data.
REQ-016 SHALL have port level  output  5  current queue occupancy.
REQ-017 SHALL have port overrun  output  1  sticky: active video began with work pending.
REQ-018 SHALL have port clr_overrun  input  1  clears overrun.

Function
REQ-019 Queue SHALL be FIFO of FIFO_DEPTH {addr,data} entries; wr_ready = (level != FIFO_DEPTH), derived from registered count only.
REQ-020 Push and pop in the same cycle SHALL leave level unchanged; push when full SHALL be impossible (wr_ready low); no empty-to-output bypass.
REQ-021 Commit permitted in a cycle iff sync_mode==0 or vblank==1.
REQ-022 Each permitted cycle, arbiter SHALL grant at most one requester: queue (level!=0) or fill (fill_busy); if both request, round-robin alternation starting with queue after reset; a sole requester always wins.
REQ-023 Granted queue SHALL pop its head that cycle; granted fill SHALL advance its row counter that cycle.
REQ-024 fb_we/fb_addr/fb_data SHALL be registered: grant in cycle N -> fb_we=1 with granted entry in cycle N+1; fb_we=0 otherwise, fb_addr/fb_data hold last value.
REQ-025 Push at edge N into empty queue with commit permitted and no fill -> fb_we high in cycle N+2.
REQ-026 Fill FSM states IDLE, FILL: IDLE->FILL on fill_start (row=0); FILL increments row per fill grant; row 15 grant -> IDLE; fill_start while FILL ignored.
REQ-027 fill_busy = (state==FILL).
REQ-028 Overrun SHALL set on cycle where vblank falls (registered vblank 1, current 0), sync_mode==1, and (level!=0 or fill_busy); clr_overrun clears; simultaneous set and clear -> set wins.
REQ-029 Queue order SHALL be preserved; writes to the same row SHALL commit in push order.

Reset
REQ-030 rst_n low at a clock edge SHALL force: queue empty, level=0, wr_ready=1, state IDLE, fill_busy=0, fb_we=0, fb_addr=0, fb_data=0, overrun=0, round-robin to queue-first, vblank history=0.
REQ-031 Reset mid-fill or with queue non-empty SHALL discard pending work with no further fb_we.

Configuration
REQ-032 Macro TQVP_FB_SCHED_FILL_EN defined: fill engine per REQ-026/027 present.
REQ-033 Macro undefined: fill engine absent, fill_busy tied 0, fill_start/fill_pattern ignored, queue always wins arbitration, overrun considers queue only.

Structure
REQ-034 Package tqvp_htfab_fb_pkg SHALL hold FB_ROWS=16, FB_ROW_W=32, FB_ADDR_W=4, and the fill-state enum.
REQ-035 FIFO storage and pointers SHALL be sub-module fb_sched_fifo; arbiter, fill FSM, overrun logic in top.

Verification
REQ-036 sync_mode=0, push row3=0xDEADBEEF at edge N -> fb_we=1, fb_addr=3, fb_data=0xDEADBEEF in cycle N+2 only.
REQ-037 sync_mode=1, vblank=0, push 4 entries -> level=4, wr_ready=0, no fb_we; raise vblank -> 4 consecutive fb_we in push order, level back to 0.
REQ-038 Fill with pattern 0xAAAA5555, queue empty, sync_mode=0 -> 16 consecutive fb_we rows 0..15, then fill_busy=0.
REQ-039 Fill active plus 2 queued entries -> grants alternate queue, fill, queue, fill..., totaling 18 writes.
REQ-040 sync_mode=1, 1 entry queued, vblank falls -> overrun=1; clr_overrun pulse -> overrun=0; repeat with clr_overrun on fall cycle -> overrun=1.
REQ-041 Assert rst_n low mid-fill at row 7 -> next cycle fb_we=0, fill_busy=0, level=0, no later writes.

Source files
------------

// File: rtl/tqvp_htfab_fb_pkg.sv
// Shared framebuffer geometry, queue entry layout and fill-engine state encoding
// for the framebuffer write scheduler.
package tqvp_htfab_fb_pkg;

    localparam int unsigned FB_ROWS   = 16;
    localparam int unsigned FB_ROW_W  = 32;
    localparam int unsigned FB_ADDR_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_ROW_W-1:0]  data;
    } fb_entry_t;

endpackage

// File: rtl/tqvp_htfab_fb_sched_if.sv
// CPU row-write handshake plus the registered framebuffer write port.
interface tqvp_htfab_fb_sched_if;
    import tqvp_htfab_fb_pkg::*;

    logic                 wr_valid;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [FB_ROW_W-1:0]  wr_data;
    logic                 wr_ready;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [FB_ROW_W-1:0]  fb_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/tqvp_htfab_fb_sched_fifo.sv
// Write-queue storage and pointers; occupancy comes only from the registered count,
// so there is no empty-to-head bypass.
module fb_sched_fifo
    import tqvp_htfab_fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  fb_entry_t push_entry,
    input  logic      pop,
    output fb_entry_t head,
    output logic [4:0] level,
    output logic      ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_entry_t        mem_q [DEPTH];
    fb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;

    assign level = count_q;
    assign ready = (count_q != 5'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + 5'(push) - 5'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tqvp_htfab_fb_sched.sv
// Framebuffer write scheduler: queued CPU row writes and a whole-frame fill engine
// share one registered row-write port. Fill engine present only with TQVP_FB_SCHED_FILL_EN.
module tqvp_htfab_fb_sched
    import tqvp_htfab_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tqvp_htfab_fb_sched_if.slave bus,
    input  logic                 vblank,
    input  logic                 sync_mode,
    input  logic                 fill_start,
    input  logic [FB_ROW_W-1:0]  fill_pattern,
    output logic                 fill_busy,
    output logic [4:0]           level,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    fb_entry_t            head;
    fb_entry_t            push_entry;
    logic                 push, fifo_ready;
    logic                 commit_ok, q_req, grant_q, grant_f;
    logic [FB_ADDR_W-1:0] fill_row;
    logic [FB_ROW_W-1:0]  fill_data;

    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [FB_ROW_W-1:0]  fb_data_q, fb_data_d;
    logic                 vblank_q, overrun_q, overrun_d, ovr_set;

    assign push_entry   = '{addr: bus.wr_addr, data: bus.wr_data};
    assign push         = bus.wr_valid && fifo_ready;
    assign bus.wr_ready = fifo_ready;
    assign commit_ok    = !sync_mode || vblank;
    assign q_req        = (level != 5'd0);

    fb_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (grant_q),
        .head       (head),
        .level      (level),
        .ready      (fifo_ready)
    );

`ifdef TQVP_FB_SCHED_FILL_EN
    fill_state_e          state_q, state_d;
    logic [FB_ADDR_W-1:0] row_q, row_d;
    logic [FB_ROW_W-1:0]  pattern_q, pattern_d;
    logic                 rr_q, rr_d;

    assign fill_busy = (state_q == ST_FILL);
    assign fill_row  = row_q;
    assign fill_data = pattern_q;

    // rr_q set means fill has priority when both sides request.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pattern_d = pattern_q;
        rr_d      = rr_q;
        grant_q   = commit_ok && q_req && (!fill_busy || !rr_q);
        grant_f   = commit_ok && fill_busy && (!q_req || rr_q);
        if (grant_q) begin
            rr_d = 1'b1;
        end else if (grant_f) begin
            rr_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d   = ST_FILL;
                    row_d     = '0;
                    pattern_d = fill_pattern;
                end
            end
            ST_FILL: begin
                if (grant_f) begin
                    row_d = row_q + 1'b1;
                    if (row_q == FB_ADDR_W'(FB_ROWS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            pattern_q <= '0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pattern_q <= pattern_d;
            rr_q      <= rr_d;
        end
    end
`else
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_pattern};
    assign fill_busy   = 1'b0;
    assign fill_row    = '0;
    assign fill_data   = '0;
    assign grant_q     = commit_ok && q_req;
    assign grant_f     = 1'b0;
`endif

    always_comb begin
        fb_we_d   = grant_q || grant_f;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (grant_q) begin
            fb_addr_d = head.addr;
            fb_data_d = head.data;
        end else if (grant_f) begin
            fb_addr_d = fill_row;
            fb_data_d = fill_data;
        end
        ovr_set   = vblank_q && !vblank && sync_mode && (q_req || fill_busy);
        overrun_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            vblank_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            vblank_q  <= vblank;
            overrun_q <= overrun_d;
        end
    end

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign overrun     = overrun_q;

endmodule
